// File: rtl/mem_access_unit_if.sv
// Load/store request bundle between the CPU memory stage
// and mem_access_unit.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
    output ready, done, err, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store controller for a 128-word
// synchronous data memory; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          MEM_AW    = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_access_unit_if.slave  bus,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  localparam int HI = MEM_AW + 2;

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, WRITE, DONE
  } state_t;

  state_t      state;
  logic        we_r;
  logic        uns_r;
  logic [1:0]  size_r;
  logic [1:0]  off_r;
  logic [15:0] wdata_r;

  logic        bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;
  logic [31:0] merged;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (bus.size == 2'b11): bad = 1'b1;
      (bus.size == 2'b01): bad = bus.addr[0];
      (bus.size == 2'b10): bad = |bus.addr[1:0];
      default:             bad = 1'b0;
    endcase
    if (bus.addr[31:HI] != BASE_ADDR[31:HI])
      bad = 1'b1;
  end

  // Lane extraction and merge work on the captured byte offset.
  always_comb begin
    lane_b = mem_q[{off_r, 3'b000} +: 8];
    lane_h = off_r[1] ? mem_q[31:16] : mem_q[15:0];
    ld_val = mem_q;
    merged = mem_q;
    if (size_r == 2'b00) begin
      ld_val = {{24{~uns_r & lane_b[7]}}, lane_b};
      merged[{off_r, 3'b000} +: 8] = wdata_r[7:0];
    end else if (size_r == 2'b01) begin
      ld_val = {{16{~uns_r & lane_h[15]}}, lane_h};
      merged[{off_r[1], 4'b0000} +: 16] = wdata_r;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      wdata_r     <= 16'h0;
      bus.ready   <= 1'b1;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.rdata   <= 32'h0;
      mem_address <= '0;
      mem_data    <= 32'h0;
      mem_wren    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      mem_wren <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            bus.ready <= 1'b0;
            we_r      <= bus.we;
            uns_r     <= bus.unsigned_ld;
            size_r    <= bus.size;
            off_r     <= bus.addr[1:0];
            wdata_r   <= bus.wdata[15:0];
            if (bad) begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              mem_address <= bus.addr[HI-1:2];
              if (bus.we && bus.size == 2'b10) begin
                mem_data <= bus.wdata;
                mem_wren <= 1'b1;
                state    <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          if (we_r) begin
            mem_data <= merged;
            mem_wren <= 1'b1;
            state    <= WRITE;
          end else begin
            bus.rdata <= ld_val;
            bus.done  <= 1'b1;
            state     <= DONE;
          end
        end
        WRITE: begin
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.err   <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push
// expected completions and writes; negedge monitors check them.
module tb_mem_access_unit;

  localparam logic [31:0] B = 32'h1001_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q = 32'h0;
  logic [31:0] mem [128] = '{default: 32'h0};

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  exp_t sbq[$];
  wr_t  wq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_err"}, 32'(bus.err), 32'(e.err));
        check({e.name, "_rdata"}, bus.rdata, e.rd);
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && mem_wren) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check("write_addr", 32'(mem_address), 32'(w.a));
        check("write_data", mem_data, w.d);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || wq.size() != 0) && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (sbq.size() != 0 || wq.size() != 0) begin
      check("drain_timeout", 32'(sbq.size() + wq.size()), 32'd0);
      sbq.delete();
      wq.delete();
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] d);
    bus.req         = 1'b1;
    bus.we          = w;
    bus.size        = sz;
    bus.unsigned_ld = u;
    bus.addr        = a;
    bus.wdata       = d;
  endtask

  task automatic op(input string nm, input logic w,
                    input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] d,
                    input int lat, input logic e,
                    input logic [31:0] rd, input logic dowr,
                    input logic [6:0] wa, input logic [31:0] wd);
    @(negedge clock);
    wait_ready();
    drive(w, sz, u, a, d);
    sbq.push_back('{nm, e, rd, cyc + lat});
    if (dowr) wq.push_back('{wa, wd});
    @(negedge clock);
    bus.req   = 1'b0;
    bus.wdata = 32'h0BAD_F00D;
    bus.addr  = 32'h0;
    drain();
  endtask

  initial begin
    bus.req = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus.req = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_maddr", 32'(mem_address), 32'h0);
    check("rst_mdata", mem_data, 32'h0);
    check("rst_wren", 32'(mem_wren), 32'd0);
    reset_n = 1'b1;

    op("wst", 1, 2'b10, 0, B + 32'h10, 32'hDEADBEEF,
       2, 0, 32'h0, 1, 7'd4, 32'hDEADBEEF);

    // Second store, reset lands in its WRITE cycle.
    @(negedge clock);
    wait_ready();
    drive(1'b1, 2'b10, 1'b0, B + 32'h10, 32'h1234_5678);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check("rstw_wren", 32'(mem_wren), 32'd0);
    check("rstw_ready", 32'(bus.ready), 32'd1);
    @(negedge clock);
    check("rstw_done", 32'(bus.done), 32'd0);
    check("rstw_mem", mem[4], 32'hDEADBEEF);
    reset_n = 1'b1;

    op("lb_s", 0, 2'b00, 0, B + 32'h12, 0, 3, 0, 32'hFFFFFFAD,
       0, 7'd0, 32'h0);
    op("lb_u", 0, 2'b00, 1, B + 32'h12, 0, 3, 0, 32'h000000AD,
       0, 7'd0, 32'h0);
    op("lh_s", 0, 2'b01, 0, B + 32'h12, 0, 3, 0, 32'hFFFFDEAD,
       0, 7'd0, 32'h0);
    op("lh_u", 0, 2'b01, 1, B + 32'h10, 0, 3, 0, 32'h0000BEEF,
       0, 7'd0, 32'h0);
    op("sb", 1, 2'b00, 0, B + 32'h11, 32'h00000055, 4, 0,
       32'h0000BEEF, 1, 7'd4, 32'hDEAD55EF);
    op("lw", 0, 2'b10, 0, B + 32'h10, 0, 3, 0, 32'hDEAD55EF,
       0, 7'd0, 32'h0);
    op("sh_mis", 1, 2'b01, 0, B + 32'h3, 32'hFFFF, 1, 1,
       32'hDEAD55EF, 0, 7'd0, 32'h0);
    op("lw_mis", 0, 2'b10, 0, B + 32'h2, 0, 1, 1,
       32'hDEAD55EF, 0, 7'd0, 32'h0);
    op("sw_oor", 1, 2'b10, 0, B + 32'h200, 32'h1, 1, 1,
       32'hDEAD55EF, 0, 7'd0, 32'h0);
    op("sz11", 1, 2'b11, 0, B + 32'h10, 32'h1, 1, 1,
       32'hDEAD55EF, 0, 7'd0, 32'h0);
    op("sh_s", 1, 2'b01, 0, B + 32'h22, 32'hCAFE1234, 4, 0,
       32'hDEAD55EF, 1, 7'd8, 32'h12340000);
    check("sz11_mem", mem[4], 32'hDEAD55EF);

    // req pulsed while busy must be dropped.
    @(negedge clock);
    wait_ready();
    drive(1'b0, 2'b10, 1'b0, B + 32'h10, 32'h0);
    sbq.push_back('{"busy_lw", 1'b0, 32'hDEAD55EF, cyc + 3});
    @(negedge clock);
    drive(1'b1, 2'b10, 1'b0, B + 32'h14, 32'hFFFF_FFFF);
    @(negedge clock);
    bus.req = 1'b0;
    drain();
    op("lw5", 0, 2'b10, 0, B + 32'h14, 0, 3, 0, 32'h0,
       0, 7'd0, 32'h0);

    // req held high: two stores one IDLE cycle apart.
    @(negedge clock);
    wait_ready();
    drive(1'b1, 2'b10, 1'b0, B + 32'h18, 32'hA5A5_A5A5);
    sbq.push_back('{"held1", 1'b0, 32'h0, cyc + 2});
    sbq.push_back('{"held2", 1'b0, 32'h0, cyc + 5});
    wq.push_back('{7'd6, 32'hA5A5_A5A5});
    wq.push_back('{7'd6, 32'hA5A5_A5A5});
    repeat (4) @(negedge clock);
    bus.req = 1'b0;
    drain();
    op("lw6", 0, 2'b10, 0, B + 32'h18, 0, 3, 0, 32'hA5A5A5A5,
       0, 7'd0, 32'h0);

    repeat (4) @(negedge clock);
    check("sbq_empty", 32'(sbq.size()), 32'd0);
    check("wq_empty", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
